ibis_dvi_video_source: RTL and testbench
========================================

# ibis_dvi_video_source

Parametrised successor to the fixed 640x480 DVI test path. It contains a video timing generator with configurable resolution, porches and sync polarity. Per frame it selects between a streamed pixel input (valid/ready with start-of-frame and end-of-line markers) and three built-in patterns. It runs in the pixel clock domain and drives registered `{pixel, data_enable, hsync, vsync}` into the three `ibis_tmds` channel encoders.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line
- `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal porch/sync lengths in pixels
- `V_ACTIVE`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical lengths in lines
- `HSYNC_POL`, 0; `VSYNC_POL`, 0: asserted level of each sync output
- `UNDERFLOW_COLOR`, 24'hFF00FF: RGB emitted for a starved active pixel

Ports (HW = clog2(H_TOTAL), VW = clog2(V_TOTAL)):
- `aclk` in 1: pixel clock. Single clock; reset is asynchronous and active-low.
- `aresetn` in 1: asynchronous active-low reset
- `enable` in 1: run/hold
- `mode` in 2: 0 stream, 1 colour bars, 2 solid, 3 gradient
- `cfg_color` in 24: solid-fill RGB `{r,g,b}`
- `s_tdata` in 24, `s_tvalid` in 1, `s_tuser` in 1 (SOF), `s_tlast` in 1 (EOL): pixel stream
- `s_tready` out 1: stream accept
- `red`, `grn`, `blu` out 8 each: pixel to encoders
- `data_enable`, `hsync`, `vsync` out 1 each: to encoders
- `ord_x` out HW, `ord_y` out VW: coordinates of the current output pixel
- `frame_start` out 1: one-cycle pulse coincident with output pixel (0,0)
- `underflow` out 1, `sync_err` out 1: sticky status, cleared only by reset

## Operation
- H_TOTAL = sum of H params; V_TOTAL likewise. Counters `h` run 0..H_TOTAL-1; at wrap, `v` increments 0..V_TOTAL-1 and wraps to 0.
- Active region: `h<H_ACTIVE && v<V_ACTIVE`. hsync is asserted for `H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC`; vsync likewise on `v`. Output level is the `*_POL` parameter when asserted and its inverse otherwise.
- `mode` is latched into `mode_q` only at h=0,v=0. Changes mid-frame take effect at the next frame.
- Colour bars: 8 vertical bars of width H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00). Pixels beyond 8*(H_ACTIVE/8) are black.
- Gradient: r=h[7:0], g=v[7:0], b=h[7:0]^v[7:0].
- Outside the active region, RGB=0 and data_enable=0 in all modes.
- Stream FSM, states SEEK and RUN:
  - SEEK: `s_tready=1` and any beat with `s_tuser=0` is discarded. With `s_tuser=1` at the head, `s_tready=0` and the beat is held until h=0,v=0, then the FSM enters RUN and consumes it there.
  - RUN: at each active pixel `s_tready=1`. On `s_tvalid=1` the beat is consumed and displayed. Outside the active region `s_tready=0`.
  - Underflow: `s_tvalid=0` at an active pixel in RUN outputs UNDERFLOW_COLOR for that pixel and each remaining active pixel of the frame, sets `underflow`, and moves to SEEK.
  - Framing error: a consumed beat with `s_tuser` different from `(h==0&&v==0)` sets `sync_err` and moves to SEEK; the pixel is still displayed. A consumed beat with `s_tlast` different from `(h==H_ACTIVE-1)` sets `sync_err` and the FSM stays in RUN.
  - Entering stream mode always starts in SEEK. Leaving stream mode forces SEEK.
  - While in SEEK during active pixels, the output shows UNDERFLOW_COLOR without setting `underflow`.
- `enable=0`: counters, FSM and outputs hold. `s_tready=0`. `frame_start=0`.

## Timing
- Reset values: h=v=0, FSM=SEEK, mode_q=0, RGB=0, data_enable=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, ord_x=ord_y=0, frame_start=0, underflow=0, sync_err=0, s_tready=0.
- Latency: all outputs are registered one cycle after the counter state that produced them. `ord_x`/`ord_y` equal that counter state, delayed one cycle.
- `s_tready` is combinational from the counter/FSM state; handshake completes on `s_tvalid&&s_tready` at a rising edge.
- First release from reset with enable=1: frame_start pulses on the first edge after release.
- Counter update rules: `v` advances only when `h` wraps; both wrap on the same edge at (H_TOTAL-1, V_TOTAL-1).

## Test plan
Small parameters throughout: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), POL=0.
- Timing, mode 3: 128-cycle frame period. data_enable high for 8 cycles per line on lines 0-3 (32 cycles per frame). hsync low for h=10..12, vsync low for v=5..6. frame_start period 128.
- Colour bars, H_ACTIVE=8: the 8 active pixels of each line are FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Stream, happy path: 32 beats, SOF on beat 0, EOL every 8th, always valid. Frame 2 shows beat data in order; underflow=0, sync_err=0.
- Underflow: drop s_tvalid at pixel (3,1). Output FF00FF for the rest of the active frame, underflow=1, then recovery and correct data on the next frame once a SOF beat is supplied.
- Framing: beat with s_tuser=1 arriving at pixel 5 sets sync_err=1 and moves to SEEK. Junk beats are discarded until SOF; lock returns at the next h=0,v=0.
- Mid-frame: a mode change at v=2 takes effect only at the next frame_start. enable=0 for 10 cycles stretches that line by exactly 10 cycles. aresetn low mid-line sets all outputs to their reset values asynchronously.

Source files
------------

// File: rtl/ibis_dvi_video_source.sv
// ibis_dvi_video_source: parametrised video timing generator that feeds the ibis_tmds
// encoders from either a valid/ready pixel stream or one of three built-in patterns.
module ibis_dvi_video_source #(
  parameter int          H_ACTIVE        = 640,
  parameter int          H_FRONT         = 16,
  parameter int          H_SYNC          = 96,
  parameter int          H_BACK          = 48,
  parameter int          V_ACTIVE        = 480,
  parameter int          V_FRONT         = 10,
  parameter int          V_SYNC          = 2,
  parameter int          V_BACK          = 33,
  parameter logic        HSYNC_POL       = 1'b0,
  parameter logic        VSYNC_POL       = 1'b0,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF,
  localparam int         H_TOTAL         = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int         V_TOTAL         = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int         HW              = $clog2(H_TOTAL),
  localparam int         VW              = $clog2(V_TOTAL)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [23:0]   cfg_color,
  input  logic [23:0]   s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tuser,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [7:0]    red,
  output logic [7:0]    grn,
  output logic [7:0]    blu,
  output logic          data_enable,
  output logic          hsync,
  output logic          vsync,
  output logic [HW-1:0] ord_x,
  output logic [VW-1:0] ord_y,
  output logic          frame_start,
  output logic          underflow,
  output logic          sync_err
);

  // Comparisons use one extra bit so sync windows ending exactly at the total still fit.
  localparam int            HX      = HW + 1;
  localparam int            VX      = VW + 1;
  localparam logic [HX-1:0] H_ACT   = HX'(H_ACTIVE);
  localparam logic [HX-1:0] H_EOL   = HX'(H_ACTIVE - 1);
  localparam logic [HX-1:0] HS_BEG  = HX'(H_ACTIVE + H_FRONT);
  localparam logic [HX-1:0] HS_END  = HX'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HX-1:0] H_LAST  = HX'(H_TOTAL - 1);
  localparam logic [VX-1:0] V_ACT   = VX'(V_ACTIVE);
  localparam logic [VX-1:0] VS_BEG  = VX'(V_ACTIVE + V_FRONT);
  localparam logic [VX-1:0] VS_END  = VX'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VX-1:0] V_LAST  = VX'(V_TOTAL - 1);
  localparam int            BAR_W_I = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [HX-1:0] BAR_W   = HX'(BAR_W_I);
  localparam logic [HX-1:0] BAR_END = HX'(8 * (H_ACTIVE / 8));

  localparam logic [0:0] ST_SEEK = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [0:0]    state, state_next;
  logic [1:0]    mode_q, mode_eff;
  logic [HX-1:0] hx;
  logic [VX-1:0] vx;
  logic          active, sof_pos, eol_pos, hs_act, vs_act, h_wrap, v_wrap;
  logic          ready, set_uf, set_se;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_rgb, stream_rgb, rgb_next;

  assign hx       = {1'b0, h};
  assign vx       = {1'b0, v};
  assign active   = (hx < H_ACT) && (vx < V_ACT);
  assign sof_pos  = (h == '0) && (v == '0);
  assign eol_pos  = (hx == H_EOL);
  assign hs_act   = (hx >= HS_BEG) && (hx < HS_END);
  assign vs_act   = (vx >= VS_BEG) && (vx < VS_END);
  assign h_wrap   = (hx == H_LAST);
  assign v_wrap   = (vx == V_LAST);
  // The first pixel of a frame already uses the mode being latched on that edge.
  assign mode_eff = sof_pos ? mode : mode_q;
  assign s_tready = ready;

  always_comb begin
    bar_idx = 3'(hx / BAR_W);
    if (hx >= BAR_END) bar_rgb = '0;
    else bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
  end

  // A held SOF beat waits for (0,0); everything else seen while seeking is discarded.
  always_comb begin
    ready      = 1'b0;
    state_next = state;
    set_uf     = 1'b0;
    set_se     = 1'b0;
    stream_rgb = UNDERFLOW_COLOR;
    if (aresetn && enable) begin
      if (mode_eff != 2'd0) begin
        state_next = ST_SEEK;
      end else begin
        if (state == ST_RUN) ready = active;
        else ready = sof_pos || !(s_tvalid && s_tuser);
        if (state == ST_RUN && active && !s_tvalid) begin
          set_uf     = 1'b1;
          state_next = ST_SEEK;
        end else if (s_tvalid && ready && (state == ST_RUN || s_tuser)) begin
          stream_rgb = s_tdata;
          state_next = ST_RUN;
          if (s_tuser != sof_pos) begin
            set_se     = 1'b1;
            state_next = ST_SEEK;
          end
          if (s_tlast != eol_pos) set_se = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rgb_next = '0;
    if (active) begin
      case (mode_eff)
        2'd0:    rgb_next = stream_rgb;
        2'd1:    rgb_next = bar_rgb;
        2'd2:    rgb_next = cfg_color;
        default: rgb_next = {8'(h), 8'(v), 8'(h) ^ 8'(v)};
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      h           <= '0;
      v           <= '0;
      state       <= ST_SEEK;
      mode_q      <= 2'd0;
      {red, grn, blu} <= '0;
      data_enable <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      ord_x       <= '0;
      ord_y       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      sync_err    <= 1'b0;
    end else if (enable) begin
      h <= h_wrap ? '0 : h + 1'b1;
      if (h_wrap) v <= v_wrap ? '0 : v + 1'b1;
      if (sof_pos) mode_q <= mode;
      state           <= state_next;
      {red, grn, blu} <= rgb_next;
      data_enable     <= active;
      hsync           <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync           <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      ord_x           <= h;
      ord_y           <= v;
      frame_start     <= sof_pos;
      if (set_uf) underflow <= 1'b1;
      if (set_se) sync_err <= 1'b1;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ibis_dvi_video_source.sv
// Bench for ibis_dvi_video_source: random pixel data and colours checked against a
// frame-position reference model of timing, patterns and stream locking.
module tb_ibis_dvi_video_source;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        aclk, aresetn, enable;
  logic [1:0]  mode;
  logic [23:0] cfg_color, s_tdata;
  logic        s_tvalid, s_tuser, s_tlast, s_tready;
  logic [7:0]  red, grn, blu;
  logic        data_enable, hsync, vsync;
  logic [3:0]  ord_x;
  logic [2:0]  ord_y;
  logic        frame_start, underflow, sync_err;

  ibis_dvi_video_source #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .UNDERFLOW_COLOR(24'hFF00FF)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode),
    .cfg_color(cfg_color), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tready(s_tready),
    .red(red), .grn(grn), .blu(blu), .data_enable(data_enable),
    .hsync(hsync), .vsync(vsync), .ord_x(ord_x), .ord_y(ord_y),
    .frame_start(frame_start), .underflow(underflow), .sync_err(sync_err)
  );

  int errors = 0, checks = 0;
  int cyc = 0, fs_prev = 0, fs_last = 0;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  // Reference model: frame position, stream lock and sticky flags.
  int          mh, mv;
  bit          m_run, m_uf, m_se;
  logic [1:0]  m_mode_q;
  logic [23:0] e_rgb;
  logic        e_de, e_hs, e_vs, e_fs;
  int          e_x, e_y;

  int          beat_n;
  logic [23:0] hd_data;
  logic        hd_user, hd_last;
  bit          drop;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ".rgb"}, 32'({red, grn, blu}), 32'(e_rgb));
    checkOutput({where, ".de"}, 32'(data_enable), 32'(e_de));
    checkOutput({where, ".hsync"}, 32'(hsync), 32'(e_hs));
    checkOutput({where, ".vsync"}, 32'(vsync), 32'(e_vs));
    checkOutput({where, ".frame_start"}, 32'(frame_start), 32'(e_fs));
    checkOutput({where, ".ord_x"}, 32'(ord_x), 32'(e_x));
    checkOutput({where, ".ord_y"}, 32'(ord_y), 32'(e_y));
    checkOutput({where, ".underflow"}, 32'(underflow), 32'(m_uf));
    checkOutput({where, ".sync_err"}, 32'(sync_err), 32'(m_se));
  endtask

  task automatic modelReset();
    mh = 0; mv = 0; m_run = 0; m_uf = 0; m_se = 0; m_mode_q = 2'd0;
    e_rgb = '0; e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_x = 0; e_y = 0;
  endtask

  task automatic nextBeat();
    beat_n++;
    hd_data = 24'($urandom);
    hd_user = (beat_n % 32 == 0);
    hd_last = (beat_n % 8 == 7);
  endtask

  // One pixel clock: drive at the falling edge, predict, check after the rising edge.
  task automatic applyStimulus();
    bit          first, act, rdy, take;
    logic [1:0]  md;
    logic [23:0] px;
    cyc++;
    s_tvalid = !(drop && mh == 3 && mv == 1);
    s_tdata  = hd_data;
    s_tuser  = hd_user;
    s_tlast  = hd_last;
    first = (mh == 0 && mv == 0);
    act   = (mh < HA) && (mv < VA);
    md    = first ? mode : m_mode_q;
    if (!enable || md != 2'd0) rdy = 0;
    else if (m_run) rdy = act;
    else rdy = first || !(s_tvalid && s_tuser);
    take = s_tvalid && rdy;
    #1;
    checkOutput("s_tready", 32'(s_tready), 32'(rdy));
    if (enable) begin
      px = '0;
      if (act) begin
        case (md)
          2'd0:    px = (take && (m_run || s_tuser)) ? s_tdata : 24'hFF00FF;
          2'd1:    px = bars[mh];
          2'd2:    px = cfg_color;
          default: px = {8'(mh), 8'(mv), 8'(mh ^ mv)};
        endcase
      end
      e_rgb = px;
      e_de  = act;
      e_hs  = !(mh >= HA + HF && mh < HA + HF + HS);
      e_vs  = !(mv >= VA + VF && mv < VA + VF + VS);
      e_fs  = first;
      e_x   = mh;
      e_y   = mv;
      if (md != 2'd0) m_run = 0;
      else if (m_run) begin
        if (act && !s_tvalid) begin
          m_uf = 1; m_run = 0;
        end else if (take) begin
          if (s_tuser != first) begin m_se = 1; m_run = 0; end
          if (s_tlast != (mh == HA - 1)) m_se = 1;
        end
      end else if (take && s_tuser) begin
        m_run = 1;
        if (s_tlast != (mh == HA - 1)) m_se = 1;
      end
      if (first) m_mode_q = mode;
      mh++;
      if (mh == HT) begin
        mh = 0; mv++;
        if (mv == VT) mv = 0;
      end
    end else begin
      e_fs = 0;
    end
    @(posedge aclk);
    #1;
    checkAll("px");
    if (frame_start === 1'b1) begin fs_prev = fs_last; fs_last = cyc; end
    if (data_enable === 1'b1) de_cnt++;
    if (hsync === 1'b0) hs_cnt++;
    if (vsync === 1'b0) vs_cnt++;
    if (take) nextBeat();
    @(negedge aclk);
  endtask

  task automatic runTo(input int x, input int y, input int limit);
    int n = 0;
    while (!(mh == x && mv == y) && n < limit) begin
      applyStimulus();
      n++;
    end
    if (!(mh == x && mv == y)) begin
      checks++;
      errors++;
      $error("[TB] FAIL runTo observed=%0d,%0d expected=%0d,%0d", mh, mv, x, y);
    end
  endtask

  initial begin
    aresetn = 1; enable = 1; mode = 2'd3; cfg_color = '0; drop = 0;
    s_tvalid = 0; s_tdata = '0; s_tuser = 0; s_tlast = 0;
    beat_n = 0; hd_data = 24'($urandom); hd_user = 1; hd_last = 0;
    modelReset();
    #1 aresetn = 0;
    @(negedge aclk);
    checkAll("reset");
    checkOutput("reset.s_tready", 32'(s_tready), 32'd0);
    aresetn = 1;

    // Gradient timing over two whole frames from release.
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    repeat (2 * HT * VT) applyStimulus();
    checkOutput("de_count", 32'(de_cnt), 32'd64);
    checkOutput("hsync_low_count", 32'(hs_cnt), 32'd48);
    checkOutput("vsync_low_count", 32'(vs_cnt), 32'd64);
    checkOutput("fs_period", 32'(fs_last - fs_prev), 32'd128);

    // Mode change on line 2 only lands at the next frame.
    runTo(0, 2, 200);
    mode = 2'd1;
    runTo(0, 0, 200);
    applyStimulus();
    checkOutput("bar0", 32'({red, grn, blu}), 32'hFFFFFF);
    applyStimulus();
    checkOutput("bar1", 32'({red, grn, blu}), 32'hFFFF00);
    repeat (HT * VT - 2) applyStimulus();

    // Solid colour with a 10-cycle stall inside the frame.
    cfg_color = 24'($urandom);
    mode = 2'd2;
    runTo(0, 0, 200);
    applyStimulus();
    runTo(4, 1, 200);
    enable = 0;
    repeat (10) applyStimulus();
    enable = 1;
    runTo(0, 0, 300);
    applyStimulus();
    checkOutput("stall_fs_period", 32'(fs_last - fs_prev), 32'd138);

    // Stream happy path.
    mode = 2'd0;
    runTo(0, 0, 200);
    repeat (3 * HT * VT) applyStimulus();
    checkOutput("happy_underflow", 32'(underflow), 32'd0);
    checkOutput("happy_sync_err", 32'(sync_err), 32'd0);

    // Starve pixel (3,1), then recover on the next SOF.
    runTo(0, 0, 200);
    drop = 1;
    repeat (HT * VT) applyStimulus();
    drop = 0;
    checkOutput("underflow_set", 32'(underflow), 32'd1);
    repeat (2 * HT * VT) applyStimulus();

    // Early SOF at pixel 5 of line 0.
    runTo(5, 0, 200);
    hd_user = 1;
    applyStimulus();
    checkOutput("sync_err_set", 32'(sync_err), 32'd1);
    repeat (2 * HT * VT) applyStimulus();

    // Asynchronous reset in the middle of a line.
    runTo(3, 2, 200);
    #2 aresetn = 0;
    #1;
    modelReset();
    checkAll("reset_mid");
    checkOutput("reset_mid.s_tready", 32'(s_tready), 32'd0);
    @(negedge aclk);
    aresetn = 1;
    applyStimulus();
    checkOutput("fs_after_reset", 32'(frame_start), 32'd1);
    repeat (2 * HT * VT) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
